// File: rtl/decl_emitter_if.sv
// Character-stream handshake bundle for decl_emitter: request/capture inputs,
// a valid/ready character output, and busy/done status.
interface decl_emitter_if;
  logic       start;
  logic [2:0] var_count;
  logic [2:0] name_len;
  logic [7:0] out_char;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  modport master (
    output start, var_count, name_len, out_ready,
    input  out_char, out_valid, busy, done
  );

  modport slave (
    input  start, var_count, name_len, out_ready,
    output out_char, out_valid, busy, done
  );
endinterface

// File: rtl/decl_emitter.sv
// Streams a C declaration such as "int a12, b12;" one character per accepted transfer.
// Define DECL_SPACE_AFTER_COMMA_EN to emit a space after every comma.
module decl_emitter #(
  parameter int LEAD_SPACES = 0
) (
  input  logic           clk,
  input  logic           reset,
  decl_emitter_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE, LEAD, KW, SP, NAME, COMMA, CSP, SEMI, DONE
  } state_t;

  localparam logic [1:0] LEAD_LAST = (LEAD_SPACES > 0) ? 2'(LEAD_SPACES - 1) : 2'd0;

  state_t     state_q, state_d;
  logic [1:0] lead_q, lead_d;
  logic [1:0] kw_q, kw_d;
  logic [2:0] id_q, id_d;
  logic [2:0] ci_q, ci_d;
  logic [2:0] vc_q, vc_d;
  logic [2:0] nl_q, nl_d;
  logic [7:0] out_char_q, out_char_d;
  logic       out_valid_q, out_valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       xfer;

  // Character offered while sitting in state s with the given counter values.
  function automatic logic [7:0] char_of(state_t s, logic [1:0] kw, logic [2:0] id,
                                         logic [2:0] ci);
    logic [7:0] c;
    c = 8'h00;
    case (s)
      LEAD:  c = 8'h20;
      KW: begin
        case (kw)
          2'd0:    c = 8'h69;
          2'd1:    c = 8'h6e;
          default: c = 8'h74;
        endcase
      end
      SP:    c = 8'h20;
      NAME:  c = (ci == 3'd0) ? (8'h61 + {5'd0, id}) : (8'h30 + {5'd0, ci});
      COMMA: c = 8'h2c;
      CSP:   c = 8'h20;
      SEMI:  c = 8'h3b;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  assign xfer = out_valid_q && bus.out_ready;

  always_comb begin
    state_d = state_q;
    lead_d  = lead_q;
    kw_d    = kw_q;
    id_d    = id_q;
    ci_d    = ci_q;
    vc_d    = vc_q;
    nl_d    = nl_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          vc_d    = (bus.var_count == 3'd0) ? 3'd1 : bus.var_count;
          nl_d    = (bus.name_len == 3'd0) ? 3'd1 : bus.name_len;
          lead_d  = 2'd0;
          kw_d    = 2'd0;
          id_d    = 3'd0;
          ci_d    = 3'd0;
          state_d = (LEAD_SPACES > 0) ? LEAD : KW;
        end
      end
      LEAD: begin
        if (xfer) begin
          if (lead_q == LEAD_LAST) state_d = KW;
          else                     lead_d  = lead_q + 2'd1;
        end
      end
      KW: begin
        if (xfer) begin
          if (kw_q == 2'd2) state_d = SP;
          else              kw_d    = kw_q + 2'd1;
        end
      end
      SP: begin
        if (xfer) state_d = NAME;
      end
      NAME: begin
        if (xfer) begin
          if (ci_q == nl_q - 3'd1) begin
            ci_d    = 3'd0;
            state_d = (id_q == vc_q - 3'd1) ? SEMI : COMMA;
          end else begin
            ci_d = ci_q + 3'd1;
          end
        end
      end
      COMMA: begin
        if (xfer) begin
          id_d = id_q + 3'd1;
`ifdef DECL_SPACE_AFTER_COMMA_EN
          state_d = CSP;
`else
          state_d = NAME;
`endif
        end
      end
      CSP: begin
        if (xfer) state_d = NAME;
      end
      SEMI: begin
        if (xfer) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are computed from the next state so they are registered yet current.
    out_valid_d = !(state_d inside {IDLE, DONE});
    out_char_d  = out_valid_d ? char_of(state_d, kw_d, id_d, ci_d) : 8'h00;
    busy_d      = out_valid_d;
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lead_q      <= 2'd0;
      kw_q        <= 2'd0;
      id_q        <= 3'd0;
      ci_q        <= 3'd0;
      vc_q        <= 3'd0;
      nl_q        <= 3'd0;
      out_char_q  <= 8'h00;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lead_q      <= lead_d;
      kw_q        <= kw_d;
      id_q        <= id_d;
      ci_q        <= ci_d;
      vc_q        <= vc_d;
      nl_q        <= nl_d;
      out_char_q  <= out_char_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.out_char  = out_char_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: doc/decl_emitter.md
DECL_EMITTER -- requirements
Module: decl_emitter

Interface
REQ-001 Parameter LEAD_SPACES, default 0, number of ' ' (8'h20) characters emitted before "int" (legal range 0..3).
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to emit one declaration; sampled only in IDLE.
REQ-005 var_count  input  3  number of identifiers to emit, captured on accepted start; 0 treated as 1.
REQ-006 name_len  input  3  characters per identifier, captured on accepted start; 0 treated as 1.
REQ-007 out_char  output  8  ASCII character currently offered.
REQ-008 out_valid  output  1  out_char is valid.
REQ-009 out_ready  input  1  downstream accepts out_char this cycle.
REQ-010 busy  output  1  high from the cycle after start is accepted through the cycle the ';' is accepted.
REQ-011 done  output  1  one-cycle pulse in the cycle after the ';' is accepted.

Function
REQ-012 The block SHALL emit a well-formed declaration: LEAD_SPACES spaces, "int", one space, var_count identifiers separated by separators, then ";".
REQ-013 Identifier k (k = 0..var_count-1) SHALL be the letter 'a'+k followed by name_len-1 digits '1','2',...; e.g. k=1, name_len=3 -> "b12".
REQ-014 A character transfers when out_valid && out_ready; out_char SHALL remain stable while out_valid && !out_ready.
REQ-015 FSM states: IDLE, LEAD, KW, SP, NAME, COMMA, CSP, SEMI, DONE; SEMI is left only on a transfer; DONE lasts exactly one cycle then returns to IDLE.
REQ-016 Transitions: IDLE->LEAD (LEAD_SPACES>0) or KW on start; LEAD->KW after LEAD_SPACES transfers; KW->SP after 'i','n','t' transfer; SP->NAME; NAME->COMMA after name_len chars if identifiers remain, else ->SEMI; COMMA->CSP or NAME per REQ-024; CSP->NAME.
REQ-017 Latency: start accepted in IDLE at cycle N -> out_valid=1 at cycle N+1 with first character; with out_ready held 1, one character per cycle, no bubbles.
REQ-018 start while not IDLE SHALL be ignored; var_count/name_len changes after capture SHALL have no effect.
REQ-019 out_valid SHALL be 0 in IDLE and DONE; out_char SHALL be 8'h00 when out_valid=0.
REQ-020 Internal counters: 2-bit lead, 2-bit keyword index, 3-bit identifier index, 3-bit character index; all reset to 0 at start acceptance.

Reset
REQ-021 reset SHALL return the FSM to IDLE within one clock regardless of state, including mid-transfer with out_valid=1 and out_ready=0.
REQ-022 Reset values: out_char=8'h00, out_valid=0, busy=0, done=0, all counters 0, captured var_count/name_len 0.
REQ-023 reset has priority over start in the same cycle; the partial declaration is abandoned with no done pulse.

Configuration
REQ-024 Macro DECL_SPACE_AFTER_COMMA_EN: defined -> each ',' followed by one ' ' (COMMA->CSP->NAME); undefined -> COMMA->NAME directly, no space.

Verification
REQ-025 Macro defined, LEAD_SPACES=0, var_count=2, name_len=3, out_ready=1 -> "int a12, b12;" over 13 consecutive cycles starting 1 cycle after start; done pulses next cycle.
REQ-026 Macro undefined, same stimulus -> "int a12,b12;" in 12 cycles; done one cycle after ';'.
REQ-027 var_count=0, name_len=0, LEAD_SPACES=2 -> "  int a;" (8 chars); single-char identifier.
REQ-028 out_ready toggled 1,0,0,1,... -> out_char holds during stalls, stream identical to REQ-025, no character dropped or duplicated.
REQ-029 reset asserted while 'b' offered with out_ready=0 -> next cycle out_valid=0, busy=0, no done; new start then produces a full declaration from 'i'.
REQ-030 start pulsed again during emission with different var_count -> ignored; output matches original capture.
